// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple_proc core: opcodes, FSM states and
// instruction field positions.
package simple_proc_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int III_MSB = 15;
   localparam int III_LSB = 13;
   localparam int I_BIT   = 12;
   localparam int RX_MSB  = 11;
   localparam int RX_LSB  = 9;
   localparam int RY_MSB  = 2;
   localparam int RY_LSB  = 0;
   localparam int D_MSB   = 8;
   localparam int D_LSB   = 0;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/simple_proc_regfile.sv
// 8x16 register file: one write port, two combinational read ports, sync reset.
// SIMPLE_PROC_DBG_EN adds a third combinational read port for debug.
module simple_proc_regfile (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [2:0]  waddr_i,
   input  logic [15:0] wdata_i,
   input  logic [2:0]  raddr_a_i,
   output logic [15:0] rdata_a_o,
   input  logic [2:0]  raddr_b_i,
   output logic [15:0] rdata_b_o
`ifdef SIMPLE_PROC_DBG_EN
   ,
   input  logic [2:0]  dbg_raddr_i,
   output logic [15:0] dbg_rdata_o
`endif
);

   logic [15:0] regs_q [8];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

`ifdef SIMPLE_PROC_DBG_EN
   assign dbg_rdata_o = regs_q[dbg_raddr_i];
`endif

endmodule

// File: rtl/simple_proc.sv
// Multicycle 16-bit core executing mv/mvt/add/sub words presented on DIN.
// SIMPLE_PROC_DBG_EN adds dbg_sel/dbg_rdata/dbg_state observation ports.
module simple_proc
   import simple_proc_pkg::*;
(
   input  logic        clk_50MHz,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] DIN,
   output logic        done
`ifdef SIMPLE_PROC_DBG_EN
   ,
   input  logic [2:0]  dbg_sel,
   output logic [15:0] dbg_rdata,
   output logic [1:0]  dbg_state
`endif
);

   state_t      state_q;
   logic [15:0] ir_q;
   logic [15:0] a_q;
   logic [15:0] g_q;
   logic        done_q;

   logic [2:0]  ir_op;
   logic [15:0] rdata_a;
   logic [15:0] rdata_b;
   logic [15:0] operand;
   logic        we;
   logic [15:0] wdata;

   assign ir_op   = ir_q[III_MSB:III_LSB];
   assign operand = ir_q[I_BIT] ? {7'd0, ir_q[D_MSB:D_LSB]} : rdata_b;

   simple_proc_regfile u_regfile (
      .clk_i       (clk_50MHz),
      .rst_i       (reset),
      .we_i        (we),
      .waddr_i     (ir_q[RX_MSB:RX_LSB]),
      .wdata_i     (wdata),
      .raddr_a_i   (ir_q[RX_MSB:RX_LSB]),
      .rdata_a_o   (rdata_a),
      .raddr_b_i   (ir_q[RY_MSB:RY_LSB]),
      .rdata_b_o   (rdata_b)
`ifdef SIMPLE_PROC_DBG_EN
      ,
      .dbg_raddr_i (dbg_sel),
      .dbg_rdata_o (dbg_rdata)
`endif
   );

   // Writes land on the edge that closes the done cycle (T1 for moves, T3 for ALU ops).
   always_comb begin
      we    = 1'b0;
      wdata = operand;
      case (state_q)
         T1: begin
            if (ir_op == OP_MV) begin
               we = 1'b1;
            end else if (ir_op == OP_MVT) begin
               we    = 1'b1;
               wdata = {ir_q[7:0], 8'h00};
            end
         end
         T3: begin
            we    = 1'b1;
            wdata = g_q;
         end
         default: ;
      endcase
   end

   // done is registered on entry to the completing state, so it is a clean Moore strobe.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q <= T0;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            T0: begin
               done_q <= 1'b0;
               if (run) begin
                  ir_q    <= DIN;
                  state_q <= T1;
                  done_q  <= !is_arith(DIN[III_MSB:III_LSB]);
               end
            end
            T1: begin
               done_q <= 1'b0;
               if (is_arith(ir_op)) begin
                  a_q     <= rdata_a;
                  state_q <= T2;
               end else begin
                  state_q <= T0;
               end
            end
            T2: begin
               g_q     <= (ir_op == OP_SUB) ? (a_q - operand) : (a_q + operand);
               state_q <= T3;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= T0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign done = done_q;

`ifdef SIMPLE_PROC_DBG_EN
   assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_simple_proc.sv
// Directed self-checking bench for simple_proc: latency, arithmetic wrap,
// reserved ops, mid-instruction reset and back-to-back issue.
module tb_simple_proc;

   logic        clk_50MHz = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] DIN;
   logic        done;

   int checks = 0;
   int errors = 0;

   simple_proc dut (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .run       (run),
      .DIN       (DIN),
      .done      (done)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic [15:0] exp [8]);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_r%0d", tag, i), {16'd0, dut.u_regfile.regs_q[i]}, {16'd0, exp[i]});
   endtask

   // Issue one instruction with run for a single cycle and measure done latency.
   task automatic exec(input string tag, input logic [15:0] din, input int exp_lat);
      int lat;
      lat = 0;
      @(negedge clk_50MHz);
      run = 1'b1;
      DIN = din;
      @(posedge clk_50MHz);
      #1;
      run = 1'b0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         if (done) lat = k;
         @(posedge clk_50MHz);
         #1;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_done_width"}, {31'd0, done}, 32'd0);
   endtask

   logic [15:0] exp_r [8];
   logic [7:0]  done_vec;

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      DIN   = '0;
      for (int i = 0; i < 8; i++) exp_r[i] = '0;

      @(posedge clk_50MHz);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_50MHz);
         #1;
         check("idle_done", {31'd0, done}, 32'd0);
      end
      check("idle_state", {30'd0, dut.state_q}, 32'd0);
      check_regs("reset", exp_r);

      exec("mv_r0_imm", 16'h101C, 1);
      check("r0_28", {16'd0, dut.u_regfile.regs_q[0]}, 32'h001C);
      exec("mv_r1_r0", 16'h0200, 1);
      check("r1_copy", {16'd0, dut.u_regfile.regs_q[1]}, 32'h001C);
      exec("mvt_r1", 16'h32FF, 1);
      check("r1_mvt", {16'd0, dut.u_regfile.regs_q[1]}, 32'hFF00);
      exec("add_r1_ff", 16'h52FF, 3);
      check("r1_add", {16'd0, dut.u_regfile.regs_q[1]}, 32'hFFFF);
      exec("add_r1_wrap", 16'h5201, 3);
      check("r1_wrap", {16'd0, dut.u_regfile.regs_q[1]}, 32'h0000);
      exec("sub_r2_1", 16'h7401, 3);
      check("r2_sub", {16'd0, dut.u_regfile.regs_q[2]}, 32'hFFFF);

      exec("reserved", 16'h8000, 1);
      exp_r[0] = 16'h001C;
      exp_r[1] = 16'h0000;
      exp_r[2] = 16'hFFFF;
      check_regs("reserved", exp_r);

      exec("add_r0_r0", 16'h4000, 3);
      check("r0_double", {16'd0, dut.u_regfile.regs_q[0]}, 32'h0038);
      exec("mvt_ignore_i", 16'h26AB, 1);
      check("r3_mvt", {16'd0, dut.u_regfile.regs_q[3]}, 32'hAB00);
      exec("mv_r0_max_imm", 16'h11FF, 1);
      check("r0_1ff", {16'd0, dut.u_regfile.regs_q[0]}, 32'h01FF);

      // add r2,#5: reset lands while the core sits in T2.
      @(negedge clk_50MHz);
      run = 1'b1;
      DIN = 16'h5405;
      @(posedge clk_50MHz);
      #1;
      run = 1'b0;
      @(posedge clk_50MHz);
      #1;
      reset = 1'b1;
      @(posedge clk_50MHz);
      #1;
      reset = 1'b0;
      check("abort_state", {30'd0, dut.state_q}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) exp_r[i] = '0;
      check_regs("abort", exp_r);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_50MHz);
         #1;
         check("abort_no_done", {31'd0, done}, 32'd0);
      end

      // Back-to-back: mv r4,#3 ; add r4,#2 ; mv r5,r4 with run held high.
      done_vec = '0;
      @(negedge clk_50MHz);
      run = 1'b1;
      DIN = 16'h1803;
      for (int e = 0; e < 8; e++) begin
         @(posedge clk_50MHz);
         #1;
         done_vec[e] = done;
         if (e == 0) DIN = 16'h5802;
         if (e == 2) DIN = 16'h0A04;
         if (e == 6) run = 1'b0;
      end
      check("b2b_done_pattern", {24'd0, done_vec}, 32'h51);
      check("b2b_r4", {16'd0, dut.u_regfile.regs_q[4]}, 32'h0005);
      check("b2b_r5", {16'd0, dut.u_regfile.regs_q[5]}, 32'h0005);
      check("b2b_state", {30'd0, dut.state_q}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
